song_reader: RTL and testbench

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_reader.sv | 123 ++++++++++++
 tb/tb_song_reader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// Song sequencer: walks one of four 32-note songs in an external ROM and hands
// each note to a note player, one load strobe per note, until an end marker or the last slot.
module song_reader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [1:0]        song,
    input  logic              note_done,
    output logic [ADDR_W+1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [5:0]        note,
    output logic [5:0]        duration,
    output logic              new_note,
    output logic              song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        ISSUE,
        WAIT_DONE,
        END
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] note_idx, idx_next;
    logic [1:0]        song_latched, song_next;
    logic              resume, resume_next;
    logic              capture;
    logic              song_change;

    // resume marks a note_done that was taken while play was low: the index
    // has already advanced, and the next fetch waits only for play to return.
    assign song_change = (state != IDLE) && (song != song_latched);
    assign rom_addr    = {song_latched, note_idx};

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        idx_next    = note_idx;
        song_next   = song_latched;
        resume_next = resume;
        capture     = 1'b0;
        new_note    = 1'b0;
        song_done   = 1'b0;

        if (song_change) begin
            // An abort beats everything else, including a coincident note_done.
            state_next  = IDLE;
            idx_next    = '0;
            resume_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    song_next   = song;
                    idx_next    = '0;
                    resume_next = 1'b0;
                    if (play) state_next = FETCH;
                end
                FETCH: state_next = WAIT_ROM;
                WAIT_ROM: begin
                    capture    = 1'b1;
                    state_next = (rom_data[5:0] == 6'd0) ? END : ISSUE;
                end
                ISSUE: begin
                    new_note   = 1'b1;
                    state_next = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (resume) begin
                        if (play) begin
                            resume_next = 1'b0;
                            state_next  = FETCH;
                        end
                    end else if (note_done) begin
                        if (note_idx == LAST_IDX) begin
                            state_next = END;
                        end else begin
                            idx_next = note_idx + 1'b1;
                            if (play) state_next  = FETCH;
                            else      resume_next = 1'b1;
                        end
                    end
                end
                END: begin
                    song_done  = 1'b1;
                    idx_next   = '0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            note_idx     <= '0;
            song_latched <= 2'd0;
            resume       <= 1'b0;
            note         <= 6'd0;
            duration     <= 6'd0;
        end else begin
            state        <= state_next;
            note_idx     <= idx_next;
            song_latched <= song_next;
            resume       <= resume_next;
            if (capture) begin
                note     <= rom_data[11:6];
                duration <= rom_data[5:0];
            end
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle to a song-level model.
module tb_song_reader;

    localparam int ADDR_W = 5;
    localparam int NOTES  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic [1:0]        song;
    logic              note_done;
    logic [ADDR_W+1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [5:0]        note;
    logic [5:0]        duration;
    logic              new_note;
    logic              song_done;

    logic [11:0] rom [0:4*NOTES-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_new    = 0;
    int n_done   = 0;

    song_reader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one cycle later.
    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- song-level model ----------------
    // m_run: a song is in progress; m_age: cycles since its current fetch
    // (2 = strobe cycle, 3 = waiting for the player); m_end: end-of-song cycle.
    bit                m_run  = 1'b0;
    bit                m_end  = 1'b0;
    bit                m_hold = 1'b0;
    int                m_age  = 0;
    logic [ADDR_W-1:0] m_idx  = '0;
    logic [1:0]        m_song = 2'd0;
    logic [5:0]        m_note = 6'd0;
    logic [5:0]        m_dur  = 6'd0;

    task automatic model_step();
        logic [11:0] word;
        if (!m_run) begin
            m_song = song;
            m_idx  = '0;
            m_hold = 1'b0;
            if (play) begin
                m_run = 1'b1;
                m_end = 1'b0;
                m_age = 0;
            end
        end else if (song != m_song) begin
            m_run = 1'b0;
            m_idx = '0;
        end else if (m_end) begin
            m_run = 1'b0;
            m_idx = '0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_age == 1) begin
            word   = rom[{m_song, m_idx}];
            m_note = word[11:6];
            m_dur  = word[5:0];
            if (m_dur == 6'd0) m_end = 1'b1;
            else               m_age = 2;
        end else if (m_age == 2) begin
            m_age  = 3;
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (play) begin
                m_hold = 1'b0;
                m_age  = 0;
            end
        end else if (note_done) begin
            if (m_idx == NOTES - 1) begin
                m_end = 1'b1;
            end else begin
                m_idx = m_idx + 1'b1;
                if (play) m_age  = 0;
                else      m_hold = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run  = 1'b0;
            m_end  = 1'b0;
            m_hold = 1'b0;
            m_age  = 0;
            m_idx  = '0;
            m_song = 2'd0;
            m_note = 6'd0;
            m_dur  = 6'd0;
        end else begin
            model_step();
        end
    end

    // ---------------- note player responder ----------------
    bit nd_auto  = 1'b1;
    bit nd_rand  = 1'b0;
    int nd_delay = 5;
    int last_issue_cyc = -100;

    initial begin
        note_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            note_done = (nd_auto && (cyc == last_issue_cyc + nd_delay)) ||
                        (nd_rand && ($urandom_range(0, 5) == 0));
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic exp_new;
        logic exp_done;
        exp_new  = m_run && !m_end && (m_age == 2) && (song == m_song);
        exp_done = m_run && m_end && (song == m_song);
        check("new_note",  new_note,  exp_new);
        check("song_done", song_done, exp_done);
        check("rom_addr",  rom_addr,  {m_song, m_idx});
        check("note",      note,      m_note);
        check("duration",  duration,  m_dur);
        if (new_note) begin
            n_new++;
            last_issue_cyc = cyc;
        end
        if (song_done) n_done++;
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_song_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (song_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_new_note(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (new_note) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int saved;
        reset = 1'b0;
        play  = 1'b0;
        song  = 2'd0;
        for (int i = 0; i < 4 * NOTES; i++)
            rom[i] = {6'($urandom), 6'($urandom_range(1, 63))};
        rom[32]          = {6'd10, 6'd4};
        rom[3 * NOTES + 3] = {6'd7, 6'd0};

        repeat (3) next_cycle();
        check("rst_new_note",  new_note,  0);
        check("rst_song_done", song_done, 0);
        check("rst_rom_addr",  rom_addr,  0);
        check("rst_note",      note,      0);
        check("rst_duration",  duration,  0);
        reset = 1'b1;
        next_cycle();

        // Song 1, first note at ROM[32] = {10, 4}.
        song = 2'd1;
        play = 1'b1;
        next_cycle();
        check("fetch_addr", rom_addr, 32);
        check("fetch_no_strobe", new_note, 0);
        next_cycle();
        check("rom_wait_no_strobe", new_note, 0);
        next_cycle();
        check("issue_strobe", new_note, 1);
        check("issue_note", note, 10);
        check("issue_duration", duration, 4);

        // Abort to song 0 and park in IDLE.
        next_cycle();
        song = 2'd0;
        play = 1'b0;
        repeat (8) next_cycle();

        // Full 32-note song.
        n_new  = 0;
        n_done = 0;
        play   = 1'b1;
        wait_song_done(400, seen);
        check("full_song_done_seen", seen, 1);
        next_cycle();
        play = 1'b0;
        repeat (5) next_cycle();
        check("full_song_strobes", n_new, 32);
        check("full_song_done_pulses", n_done, 1);
        check("full_song_idle_addr", rom_addr, 0);

        // Song 3 with an end marker at note 3.
        n_new  = 0;
        n_done = 0;
        song   = 2'd3;
        play   = 1'b1;
        wait_song_done(100, seen);
        check("marker_done_seen", seen, 1);
        next_cycle();
        play = 1'b0;
        repeat (5) next_cycle();
        check("marker_strobes", n_new, 3);
        check("marker_done_pulses", n_done, 1);

        // Abort song 0 at note 7 in favour of song 2.
        n_new  = 0;
        n_done = 0;
        song   = 2'd0;
        play   = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (new_note && rom_addr == 7) begin
                seen = 1'b1;
                break;
            end
        end
        check("reach_idx7", seen, 1);
        next_cycle();
        song = 2'd2;
        wait_new_note(20, seen);
        check("abort_restart_seen", seen, 1);
        check("abort_restart_addr", rom_addr, 64);
        check("abort_no_done", n_done, 0);

        // play low while waiting: index advances, no fetch until play returns.
        next_cycle();
        play  = 1'b0;
        saved = n_new;
        repeat (12) next_cycle();
        check("pause_no_strobe", n_new, saved);
        check("pause_addr_advanced", rom_addr, 65);
        play = 1'b1;
        wait_new_note(8, seen);
        check("resume_strobe_seen", seen, 1);
        check("resume_addr", rom_addr, 65);

        // Asynchronous reset in the middle of the strobe cycle.
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_new_note",  new_note,  0);
        check("async_rst_song_done", song_done, 0);
        check("async_rst_rom_addr",  rom_addr,  0);
        check("async_rst_note",      note,      0);
        check("async_rst_duration",  duration,  0);
        saved = n_new;
        repeat (3) next_cycle();
        check("held_rst_no_strobe", n_new, saved);
        reset = 1'b1;
        play  = 1'b0;
        repeat (5) next_cycle();
        check("post_rst_idle", n_new, saved);

        // Randomized run with end markers, spurious note_done and song changes.
        reset = 1'b0;
        for (int i = 0; i < 4 * NOTES; i++)
            rom[i] = {6'($urandom), ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, 63))};
        repeat (2) next_cycle();
        reset   = 1'b1;
        nd_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            play = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 63) == 0) song = 2'($urandom);
            if ($urandom_range(0, 31) == 0) nd_delay = $urandom_range(1, 8);
            reset = ($urandom_range(0, 499) != 0);
            next_cycle();
        end
        reset = 1'b1;
        repeat (2) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
